// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between the VGA timing generator and its consumers
interface vga_timing_gen_if;
  logic        pix_en;
  logic        hsync;
  logic        vsync;
  logic [11:0] hdata;
  logic [11:0] vdata;
  logic        valid;
  logic        vblank_start;

  modport master (
    output pix_en, hsync, vsync, hdata, vdata, valid, vblank_start
  );

  modport slave (
    input pix_en, hsync, vsync, hdata, vdata, valid, vblank_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster timing with pixel clock-enable
// Optional macro VGA_TIMING_PIPE_EN delays hsync/vsync/valid by one clk to align with vram read data.
module vga_timing_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
  localparam logic [11:0] V_ACT_LAST = 12'(V_ACTIVE - 1);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 4096 || V_TOTAL > 4096 || CLK_DIV < 1) begin : g_param_check
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [DW-1:0] div_cnt, div_nxt;
  logic [11:0]   h_cnt, v_cnt, h_nxt, v_nxt;
  logic          at_pix, pix_nxt;
  logic          valid_a, hsync_a, vsync_a, vblank_q;

  always_comb begin
    at_pix  = (div_cnt == DIV_LAST);
    div_nxt = at_pix ? '0 : div_cnt + 1'b1;
    pix_nxt = (div_nxt == DIV_LAST);
    h_nxt   = h_cnt;
    v_nxt   = v_cnt;
    if (at_pix) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
      end else begin
        h_nxt = h_cnt + 12'd1;
      end
    end
  end

  // Decodes are taken from the next counter values so they land in the same cycle as hdata/vdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      h_cnt    <= H_LAST;
      v_cnt    <= V_LAST;
      valid_a  <= 1'b0;
      hsync_a  <= ~SYNC_ACTIVE;
      vsync_a  <= ~SYNC_ACTIVE;
      vblank_q <= 1'b0;
    end else begin
      div_cnt  <= div_nxt;
      h_cnt    <= h_nxt;
      v_cnt    <= v_nxt;
      valid_a  <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      hsync_a  <= ((h_nxt >= HS_START) && (h_nxt < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_a  <= ((v_nxt >= VS_START) && (v_nxt < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vblank_q <= pix_nxt && (h_nxt == H_LAST) && (v_nxt == V_ACT_LAST);
    end
  end

  assign vga.pix_en       = at_pix;
  assign vga.hdata        = h_cnt;
  assign vga.vdata        = v_cnt;
  assign vga.vblank_start = vblank_q;

`ifdef VGA_TIMING_PIPE_EN
  logic valid_p, hsync_p, vsync_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_p <= 1'b0;
      hsync_p <= ~SYNC_ACTIVE;
      vsync_p <= ~SYNC_ACTIVE;
    end else begin
      valid_p <= valid_a;
      hsync_p <= hsync_a;
      vsync_p <= vsync_a;
    end
  end

  assign vga.valid = valid_p;
  assign vga.hsync = hsync_p;
  assign vga.vsync = vsync_p;
`else
  assign vga.valid = valid_a;
  assign vga.hsync = hsync_a;
  assign vga.vsync = vsync_a;
`endif

endmodule
